// File: rtl/rtc_multi.sv
// Multi-channel timer: one shared prescaler tick drives CHANNELS independent
// IDLE/RUN/DONE counters, each with its own pending interrupt and sticky overrun.
module rtc_multi #(
  parameter int CHANNELS   = 4,
  parameter int CNT_SIZE   = 10,
  parameter int PRESC_SIZE = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [PRESC_SIZE-1:0]        presc_i,
  input  logic [CHANNELS-1:0]          en_i,
  input  logic [CHANNELS-1:0]          oneshot_i,
  input  logic [CHANNELS*CNT_SIZE-1:0] top_i,
  input  logic [CHANNELS-1:0]          int_ack_i,
  output logic [CHANNELS-1:0]          int_o,
  output logic [CHANNELS-1:0]          ovr_o,
  output logic [CHANNELS*CNT_SIZE-1:0] cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_SIZE-1:0]   CNT_ONE   = {{(CNT_SIZE-1){1'b0}}, 1'b1};
  localparam logic [PRESC_SIZE-1:0] PRESC_ONE = {{(PRESC_SIZE-1){1'b0}}, 1'b1};

  // Reset asserts asynchronously but releases two clock edges later.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic [PRESC_SIZE-1:0] presc_q, presc_d;
  logic                  tick;

  // Held at zero while every channel is disabled, so an enable always sees a full period.
  always_comb begin
    tick    = 1'b0;
    presc_d = '0;
    if (|en_i) begin
      if (presc_q == presc_i) tick = 1'b1;
      else                    presc_d = presc_q + PRESC_ONE;
    end
  end

  logic [CHANNELS-1:0][1:0]          state_q, state_d;
  logic [CHANNELS-1:0][CNT_SIZE-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][CNT_SIZE-1:0] top_w;
  logic [CHANNELS-1:0]               evt_q, evt_d;
  logic [CHANNELS-1:0]               int_q, int_d;
  logic [CHANNELS-1:0]               ovr_q, ovr_d;
  logic [CHANNELS-1:0]               ack_v;

  assign top_w = top_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      case (state_q[k])
        ST_RUN: begin
          if (!en_i[k]) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end else if (tick) begin
            if (top_w[k] == '0) begin
              cnt_d[k] = '0;
            end else if (cnt_q[k] >= top_w[k] - CNT_ONE) begin
              cnt_d[k] = '0;
              evt_d[k] = 1'b1;
              if (oneshot_i[k]) state_d[k] = ST_DONE;
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          cnt_d[k] = '0;
          if (!en_i[k]) state_d[k] = ST_IDLE;
        end
        default: begin
          cnt_d[k]   = '0;
          state_d[k] = en_i[k] ? ST_RUN : ST_IDLE;
        end
      endcase
    end
  end

  // A new event replaces an acknowledged one, so ack and event together leave int set, ovr clear.
  always_comb begin
    ack_v = int_ack_i & int_q;
    int_d = evt_q | (int_q & ~ack_v);
    ovr_d = (evt_q & int_q & ~ack_v) | (ovr_q & ~ack_v);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      state_q <= '{default: ST_IDLE};
      cnt_q   <= '0;
      evt_q   <= '0;
      int_q   <= '0;
      ovr_q   <= '0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
      int_q   <= int_d;
      ovr_q   <= ovr_d;
    end
  end

  assign int_o = int_q;
  assign ovr_o = ovr_q;
  assign cnt_o = cnt_q;

endmodule

// File: tb/tb_rtc_multi.sv
// Directed bench for rtc_multi: hand-computed counter walks, interrupt and
// overrun behaviour, one-shot re-arm, zero period, coincident events and async reset.
module tb_rtc_multi;

  localparam int CH = 4;
  localparam int CW = 10;
  localparam int PW = 8;

  logic             clk;
  logic             rst_n;
  logic [PW-1:0]    presc;
  logic [CH-1:0]    en;
  logic [CH-1:0]    oneshot;
  logic [CH*CW-1:0] top;
  logic [CH-1:0]    ack;
  logic [CH-1:0]    int_o;
  logic [CH-1:0]    ovr_o;
  logic [CH*CW-1:0] cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  rtc_multi #(.CHANNELS(CH), .CNT_SIZE(CW), .PRESC_SIZE(PW)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .presc_i   (presc),
    .en_i      (en),
    .oneshot_i (oneshot),
    .top_i     (top),
    .int_ack_i (ack),
    .int_o     (int_o),
    .ovr_o     (ovr_o),
    .cnt_o     (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int k);
    return cnt_o[k*CW +: CW];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  int          walk [6] = '{0, 1, 2, 3, 4, 0};
  logic [63:0] acc;

  initial begin
    rst_n = 1'b0; presc = '0; en = '0; oneshot = '0; top = '0; ack = '0;
    cycles(2);
    chk("rst_int", 64'(int_o), 64'd0);
    chk("rst_ovr", 64'(ovr_o), 64'd0);
    chk("rst_cnt", 64'(cnt_o), 64'd0);
    rst_n = 1'b1;
    cycles(4);

    // periodic channel 0, top=5, presc=0
    presc = 8'd0; top = {10'd0, 10'd0, 10'd0, 10'd5}; oneshot = '0; en = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("walk%0d", i), 64'(cnt_of(0)), 64'(walk[i]));
    end
    chk("int_at_wrap", 64'(int_o[0]), 64'd0);
    cyc();
    chk("int_rise", 64'(int_o[0]), 64'd1);
    chk("ovr_first", 64'(ovr_o[0]), 64'd0);
    cycles(4);
    chk("cnt_wrap2", 64'(cnt_of(0)), 64'd0);
    chk("ovr_before2", 64'(ovr_o[0]), 64'd0);
    cyc();
    chk("int_second", 64'(int_o[0]), 64'd1);
    chk("ovr_second", 64'(ovr_o[0]), 64'd1);
    ack = 4'b0001; cyc(); ack = '0;
    chk("ack_int", 64'(int_o[0]), 64'd0);
    chk("ack_ovr", 64'(ovr_o[0]), 64'd0);
    ack = 4'b0001; cyc(); ack = '0;
    chk("ack_idle_int", 64'(int_o[0]), 64'd0);
    chk("ack_idle_ovr", 64'(ovr_o[0]), 64'd0);
    cycles(3);
    chk("int_third", 64'(int_o[0]), 64'd1);
    cycles(4);
    ack = 4'b0001; cyc(); ack = '0;
    chk("ack_evt_int", 64'(int_o[0]), 64'd1);
    chk("ack_evt_ovr", 64'(ovr_o[0]), 64'd0);
    en = '0; cyc();
    chk("dis_cnt", 64'(cnt_of(0)), 64'd0);
    chk("dis_int_kept", 64'(int_o[0]), 64'd1);
    ack = 4'b0001; cyc(); ack = '0;
    chk("dis_ack", 64'(int_o[0]), 64'd0);

    // one-shot channel 1, top=2, presc=3
    presc = 8'd3; top = {10'd0, 10'd0, 10'd2, 10'd0}; oneshot = 4'b0010; en = 4'b0010;
    cycles(4);
    chk("os_cnt_t1", 64'(cnt_of(1)), 64'd1);
    cycles(3);
    chk("os_cnt_hold", 64'(cnt_of(1)), 64'd1);
    cyc();
    chk("os_cnt_wrap", 64'(cnt_of(1)), 64'd0);
    chk("os_int_wrap", 64'(int_o[1]), 64'd0);
    cyc();
    chk("os_int", 64'(int_o[1]), 64'd1);
    cycles(20);
    chk("os_done_cnt", 64'(cnt_of(1)), 64'd0);
    chk("os_done_int", 64'(int_o[1]), 64'd1);
    chk("os_done_ovr", 64'(ovr_o[1]), 64'd0);
    ack = 4'b0010; cyc(); ack = '0;
    chk("os_ack", 64'(int_o[1]), 64'd0);
    en = '0; cyc();
    en = 4'b0010;
    cycles(8);
    chk("rearm_int_pre", 64'(int_o[1]), 64'd0);
    cyc();
    chk("rearm_int", 64'(int_o[1]), 64'd1);
    ack = 4'b0010; cyc(); ack = '0;
    en = '0; cyc();

    // zero period on channel 2, then top raised mid-run
    presc = 8'd0; top = '0; oneshot = '0; en = 4'b0100;
    acc = '0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      acc = acc | 64'(cnt_of(2)) | 64'(int_o[2]);
    end
    chk("top0_quiet", acc, 64'd0);
    top = {10'd0, 10'd3, 10'd0, 10'd0};
    cyc();
    chk("top3_cnt1", 64'(cnt_of(2)), 64'd1);
    cycles(2);
    chk("top3_wrap", 64'(cnt_of(2)), 64'd0);
    chk("top3_int_pre", 64'(int_o[2]), 64'd0);
    cyc();
    chk("top3_int", 64'(int_o[2]), 64'd1);
    en = '0; ack = 4'b0100; cyc(); ack = '0;
    chk("top3_ack", 64'(int_o[2]), 64'd0);

    // four channels, tops 4,4,2,7
    presc = 8'd0; top = {10'd7, 10'd2, 10'd4, 10'd4}; oneshot = '0; en = 4'b1111;
    cycles(5);
    chk("multi_int_pre", 64'(int_o), 64'b0100);
    chk("multi_cnt3_pre", 64'(cnt_of(3)), 64'd4);
    cyc();
    chk("multi_int", 64'(int_o), 64'b0111);
    chk("multi_ovr", 64'(ovr_o), 64'b0100);
    chk("multi_cnt0", 64'(cnt_of(0)), 64'd1);
    chk("multi_cnt3", 64'(cnt_of(3)), 64'd5);

    // asynchronous reset away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_int", 64'(int_o), 64'd0);
    chk("arst_ovr", 64'(ovr_o), 64'd0);
    chk("arst_cnt", 64'(cnt_o), 64'd0);
    en = '0;
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    chk("post_rst_int", 64'(int_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
